// File: rtl/piso_serializer.sv
// ---------------------------------------------------------------------------
// piso_serializer
//   Parallel-in, serial-out transmitter. A WIDTH-bit word is accepted over a
//   valid/ready handshake and shifted out MSB first, with each bit held for
//   CLKS_PER_BIT clk cycles. ser_frame qualifies every frame bit. done pulses
//   for one cycle after the last bit period ends.
//
//   Optional feature: define SERIALIZER_PARITY_EN to append an even-parity bit
//   (XOR of the captured word) after the data bits. The frame then carries
//   WIDTH+1 bits.
//
// Parameters
//   WIDTH         data word width, 2..32
//   CLKS_PER_BIT  clk cycles per serial bit, 1..65535
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   asynchronous, active-high reset
//   in_valid   in   producer offers in_data
//   in_ready   out  block is idle and will accept a word
//   in_data    in   parallel word, sampled only on the acceptance edge
//   ser_out    out  serial data, MSB first
//   ser_frame  out  ser_out carries a valid frame bit
//   busy       out  from acceptance through the DONE cycle
//   done       out  one-cycle end-of-word pulse
// ---------------------------------------------------------------------------
module piso_serializer #(
  parameter int WIDTH        = 4,
  parameter int CLKS_PER_BIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             ser_out,
  output logic             ser_frame,
  output logic             busy,
  output logic             done
);

  localparam int BW = $clog2(WIDTH + 1);
  localparam int PW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
  localparam logic [PW-1:0] PRE_LAST = PW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_DONE   = 2'd2
`ifdef SERIALIZER_PARITY_EN
    ,
    ST_PARITY = 2'd3
`endif
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] sreg_q;
  logic [WIDTH-1:0] sreg_d;
  logic [BW-1:0]    bit_q;
  logic [PW-1:0]    pre_q;
  logic             frame_q;
  logic             busy_q;
  logic             done_q;
`ifdef SERIALIZER_PARITY_EN
  logic             par_q;
`endif

  logic pre_tc;
  logic bit_last;

  assign sreg_d   = {sreg_q[WIDTH-2:0], 1'b0};
  assign pre_tc   = (pre_q == PRE_LAST);
  assign bit_last = (bit_q == BIT_LAST);

  // in_ready is a pure decode of IDLE so reset raises it immediately.
  assign in_ready  = (state_q == ST_IDLE);
  // The bit on the line is always the shift register MSB; gating with the
  // frame flop forces 0 outside a frame. Both operands are flops.
  assign ser_out   = frame_q & sreg_q[WIDTH-1];
  assign ser_frame = frame_q;
  assign busy      = busy_q;
  assign done      = done_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sreg_q  <= '0;
      bit_q   <= '0;
      pre_q   <= '0;
      frame_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SERIALIZER_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (in_valid) begin
            sreg_q  <= in_data;
            bit_q   <= '0;
            pre_q   <= '0;
            frame_q <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= ST_SHIFT;
`ifdef SERIALIZER_PARITY_EN
            par_q   <= ^in_data;
`endif
          end
        end

        ST_SHIFT: begin
          if (pre_tc) begin
            pre_q  <= '0;
            bit_q  <= bit_q + 1'b1;
            sreg_q <= sreg_d;
            if (bit_last) begin
`ifdef SERIALIZER_PARITY_EN
              // Park the parity bit in the MSB so ser_out picks it up.
              sreg_q  <= {par_q, {(WIDTH-1){1'b0}}};
              state_q <= ST_PARITY;
`else
              frame_q <= 1'b0;
              done_q  <= 1'b1;
              state_q <= ST_DONE;
`endif
            end
          end else begin
            pre_q <= pre_q + 1'b1;
          end
        end

`ifdef SERIALIZER_PARITY_EN
        ST_PARITY: begin
          if (pre_tc) begin
            pre_q   <= '0;
            sreg_q  <= '0;
            frame_q <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            pre_q <= pre_q + 1'b1;
          end
        end
`endif

        ST_DONE: begin
          // No acceptance here: in_ready only rises once back in IDLE.
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end

        default: begin
          frame_q <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
module tb_piso_serializer;

`ifdef SERIALIZER_PARITY_EN
  localparam int NB = 5;
`else
  localparam int NB = 4;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       v1 = 1'b0, v3 = 1'b0;
  logic [3:0] d1 = '0, d3 = '0;
  logic rdy1, so1, fr1, bz1, dn1;
  logic rdy3, so3, fr3, bz3, dn3;

  piso_serializer #(.WIDTH(4), .CLKS_PER_BIT(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(v1), .in_ready(rdy1), .in_data(d1),
    .ser_out(so1), .ser_frame(fr1), .busy(bz1), .done(dn1)
  );

  piso_serializer #(.WIDTH(4), .CLKS_PER_BIT(3)) u_dut3 (
    .clk(clk), .rst(rst), .in_valid(v3), .in_ready(rdy3), .in_data(d3),
    .ser_out(so3), .ser_frame(fr3), .busy(bz3), .done(dn3)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expected frame bit b of word w: data MSB first, then parity if enabled.
  function automatic logic exp_bit(input logic [3:0] w, input int b);
    if (b < 4) return w[3-b];
    return ^w;
  endfunction

  logic o_so, o_fr, o_bz, o_dn, o_rdy;
  task automatic peek(input bit s);
    o_so  = s ? so3  : so1;
    o_fr  = s ? fr3  : fr1;
    o_bz  = s ? bz3  : bz1;
    o_dn  = s ? dn3  : dn1;
    o_rdy = s ? rdy3 : rdy1;
  endtask

  // Offer one word, drop valid and scramble in_data after acceptance, then
  // check every cycle of the frame plus the done and return-to-idle cycles.
  task automatic xmit(input bit s, input logic [3:0] w, input int cpb, input string tag);
    @(negedge clk);
    if (s) begin v3 = 1'b1; d3 = w; end else begin v1 = 1'b1; d1 = w; end
    peek(s);
    chk({tag, ".rdy0"}, o_rdy, 1'b1);
    for (int b = 0; b < NB; b++) begin
      for (int c = 0; c < cpb; c++) begin
        @(negedge clk);
        if (b == 0 && c == 0) begin
          if (s) begin v3 = 1'b0; d3 = ~w; end else begin v1 = 1'b0; d1 = ~w; end
        end
        peek(s);
        chk($sformatf("%s.b%0d.c%0d", tag, b, c), o_so, exp_bit(w, b));
        chk($sformatf("%s.fr%0d.c%0d", tag, b, c), o_fr, 1'b1);
        chk($sformatf("%s.dn%0d.c%0d", tag, b, c), o_dn, 1'b0);
        chk($sformatf("%s.bz%0d.c%0d", tag, b, c), o_bz, 1'b1);
      end
    end
    @(negedge clk);
    peek(s);
    chk({tag, ".done"}, o_dn, 1'b1);
    chk({tag, ".done_bz"}, o_bz, 1'b1);
    chk({tag, ".done_fr"}, o_fr, 1'b0);
    chk({tag, ".done_so"}, o_so, 1'b0);
    chk({tag, ".done_rdy"}, o_rdy, 1'b0);
    @(negedge clk);
    peek(s);
    chk({tag, ".idle_dn"}, o_dn, 1'b0);
    chk({tag, ".idle_bz"}, o_bz, 1'b0);
    chk({tag, ".idle_rdy"}, o_rdy, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] wa, wb;

    // Reset at power-up
    #2;
    chk("rst.so", so1, 1'b0);
    chk("rst.fr", fr1, 1'b0);
    chk("rst.bz", bz1, 1'b0);
    chk("rst.dn", dn1, 1'b0);
    chk("rst.rdy", rdy1, 1'b1);
    chk("rst.rdy3", rdy3, 1'b1);
    @(negedge clk); rst = 1'b0;

    // Reset pulse while idle
    @(negedge clk); rst = 1'b1;
    #1;
    chk("rst2.rdy", rdy1, 1'b1);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    chk("rst2.so", so1, 1'b0);
    chk("rst2.fr", fr1, 1'b0);
    chk("rst2.bz", bz1, 1'b0);
    chk("rst2.dn", dn1, 1'b0);
    chk("rst2.rdy_rel", rdy1, 1'b1);

    // Basic frames, one clk per bit and three clks per bit
    xmit(1'b0, 4'b1011, 1, "w1011");
    xmit(1'b0, 4'b1001, 1, "w1001");
    xmit(1'b1, 4'b0110, 3, "c3_0110");
    xmit(1'b1, 4'b1011, 3, "c3_1011");

    // in_valid held high with in_data changing mid-frame
    wa = 4'b1100;
    wb = 4'b0101;
    @(negedge clk); v1 = 1'b1; d1 = wa;
    for (int b = 0; b < NB; b++) begin
      @(negedge clk);
      chk($sformatf("hold.a%0d", b), so1, exp_bit(wa, b));
      chk($sformatf("hold.rdy%0d", b), rdy1, 1'b0);
      d1 = 4'(b * 5 + 3);
    end
    @(negedge clk);
    chk("hold.done", dn1, 1'b1);
    chk("hold.done_rdy", rdy1, 1'b0);
    d1 = wb;
    @(negedge clk);
    chk("hold.idle_rdy", rdy1, 1'b1);
    chk("hold.idle_bz", bz1, 1'b0);
    for (int b = 0; b < NB; b++) begin
      @(negedge clk);
      if (b == 0) begin v1 = 1'b0; d1 = 4'hF; end
      chk($sformatf("hold.b%0d", b), so1, exp_bit(wb, b));
      chk($sformatf("hold.bfr%0d", b), fr1, 1'b1);
    end
    @(negedge clk);
    chk("hold.done2", dn1, 1'b1);
    @(negedge clk);
    chk("hold.idle2", rdy1, 1'b1);

    // Reset during bit 2 of 1111
    @(negedge clk); v1 = 1'b1; d1 = 4'b1111;
    @(negedge clk); v1 = 1'b0;
    chk("abort.b0", so1, 1'b1);
    @(negedge clk);
    @(negedge clk);
    chk("abort.b2", so1, 1'b1);
    rst = 1'b1;
    #1;
    chk("abort.so", so1, 1'b0);
    chk("abort.fr", fr1, 1'b0);
    chk("abort.bz", bz1, 1'b0);
    chk("abort.rdy", rdy1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("abort.nodone%0d", i), dn1, 1'b0);
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("abort.quiet%0d", i), dn1 | fr1 | bz1, 1'b0);
    end
    xmit(1'b0, 4'b1000, 1, "after_abort");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
